boid_frame_writer: RTL and testbench

Parametrised frame sequencer between the CPU's boid-position registers and the 1-bit boid display RAM. It holds a CPU-written shadow table of up to MAX_BOIDS (x, y) positions. On each VGA frame end it snapshots the table, pulses the display-RAM clear, then emits one pixel write per valid, on-screen boid. It adds per-boid valid tracking, off-screen rejection, snapshot isolation from mid-frame CPU writes, and frame/overrun counters, none of which the single-counter sequencer has.

---
 rtl/boid_pkg.sv | 16 +
 rtl/boid_frame_writer_if.sv | 29 ++
 rtl/boid_pixel_addr.sv | 20 ++
 rtl/boid_frame_writer.sv | 130 +++++++++++++
 tb/tb_boid_frame_writer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/boid_pkg.sv
// Shared video geometry and frame-writer state encoding, also used by the
// VGA controller and the display RAM.
package boid_pkg;

   localparam int VIDEO_WIDTH         = 640;
   localparam int VIDEO_HEIGHT        = 480;
   localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
   localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/boid_frame_writer_if.sv
// CPU position bus, frame trigger and display-RAM write port of the boid
// frame writer, with status counters.
interface boid_frame_writer_if #(
   parameter int PIXEL_ADDRESS_WIDTH = boid_pkg::PIXEL_ADDRESS_WIDTH
);

   logic                           cpu_we;
   logic [31:0]                    cpu_idx;
   logic [9:0]                     cpu_x;
   logic [8:0]                     cpu_y;
   logic                           screen_end;
   logic                           disp_clear;
   logic                           disp_we;
   logic [PIXEL_ADDRESS_WIDTH-1:0] disp_addr;
   logic                           busy;
   logic [15:0]                    frame_count;
   logic [7:0]                     overrun_count;

   modport master (
      output cpu_we, cpu_idx, cpu_x, cpu_y, screen_end,
      input  disp_clear, disp_we, disp_addr, busy, frame_count, overrun_count
   );

   modport slave (
      input  cpu_we, cpu_idx, cpu_x, cpu_y, screen_end,
      output disp_clear, disp_we, disp_addr, busy, frame_count, overrun_count
   );

endinterface

// File: rtl/boid_pixel_addr.sv
// Maps a boid (x, y) position to a linear display-RAM address and flags
// whether the position lies on screen.
module boid_pixel_addr #(
   parameter int VIDEO_WIDTH         = boid_pkg::VIDEO_WIDTH,
   parameter int VIDEO_HEIGHT        = boid_pkg::VIDEO_HEIGHT,
   parameter int PIXEL_ADDRESS_WIDTH = boid_pkg::PIXEL_ADDRESS_WIDTH
) (
   input  logic [9:0]                     x,
   input  logic [8:0]                     y,
   output logic [PIXEL_ADDRESS_WIDTH-1:0] addr,
   output logic                           in_bounds
);

   assign in_bounds = (32'(x) < VIDEO_WIDTH) && (32'(y) < VIDEO_HEIGHT);

   // Constant multiplier: synthesis reduces this to shifts and adds.
   assign addr = PIXEL_ADDRESS_WIDTH'(x)
               + PIXEL_ADDRESS_WIDTH'(y) * PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);

endmodule

// File: rtl/boid_frame_writer.sv
// Snapshots the CPU boid table at each frame end, pulses a display clear and
// then emits one pixel write per valid, on-screen boid.
module boid_frame_writer
   import boid_pkg::*;
#(
   parameter int MAX_BOIDS           = 4,
   parameter int VIDEO_WIDTH         = boid_pkg::VIDEO_WIDTH,
   parameter int VIDEO_HEIGHT        = boid_pkg::VIDEO_HEIGHT,
   parameter int IDX_WIDTH           = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1,
   parameter int PIXEL_ADDRESS_WIDTH = boid_pkg::PIXEL_ADDRESS_WIDTH
) (
   input  logic               clock,
   input  logic               reset_n,
   boid_frame_writer_if.slave bus
);

   localparam int CNT_WIDTH = IDX_WIDTH + 1;

   logic [9:0]           shadow_x     [MAX_BOIDS];
   logic [8:0]           shadow_y     [MAX_BOIDS];
   logic [MAX_BOIDS-1:0] shadow_valid;
   logic [9:0]           active_x     [MAX_BOIDS];
   logic [8:0]           active_y     [MAX_BOIDS];
   logic [MAX_BOIDS-1:0] active_valid;

   state_t                         state;
   logic [CNT_WIDTH-1:0]           slot;
   logic                           screen_end_q;
   logic                           trigger;
   logic                           cpu_hit;
   logic [IDX_WIDTH-1:0]           cpu_slot;
   logic [IDX_WIDTH-1:0]           rd_slot;
   logic [PIXEL_ADDRESS_WIDTH-1:0] pix_addr;
   logic                           pix_in_bounds;
   logic                           slot_visible;

   assign trigger  = bus.screen_end & ~screen_end_q;
   assign cpu_hit  = bus.cpu_we && (bus.cpu_idx < 32'(MAX_BOIDS));
   assign cpu_slot = bus.cpu_idx[IDX_WIDTH-1:0];
   assign rd_slot  = slot[IDX_WIDTH-1:0];

   boid_pixel_addr #(
      .VIDEO_WIDTH         (VIDEO_WIDTH),
      .VIDEO_HEIGHT        (VIDEO_HEIGHT),
      .PIXEL_ADDRESS_WIDTH (PIXEL_ADDRESS_WIDTH)
   ) u_pixel_addr (
      .x         (active_x[rd_slot]),
      .y         (active_y[rd_slot]),
      .addr      (pix_addr),
      .in_bounds (pix_in_bounds)
   );

   assign slot_visible = active_valid[rd_slot] && pix_in_bounds;

   // CPU-side shadow table; writable in every state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_BOIDS; i++) begin
            shadow_x[i] <= '0;
            shadow_y[i] <= '0;
         end
         shadow_valid <= '0;
      end else if (cpu_hit) begin
         shadow_x[cpu_slot]     <= bus.cpu_x;
         shadow_y[cpu_slot]     <= bus.cpu_y;
         shadow_valid[cpu_slot] <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_BOIDS; i++) begin
            active_x[i] <= '0;
            active_y[i] <= '0;
         end
         active_valid      <= '0;
         state             <= ST_IDLE;
         slot              <= '0;
         screen_end_q      <= 1'b0;
         bus.disp_clear    <= 1'b0;
         bus.disp_we       <= 1'b0;
         bus.disp_addr     <= '0;
         bus.busy          <= 1'b0;
         bus.frame_count   <= '0;
         bus.overrun_count <= '0;
      end else begin
         screen_end_q <= bus.screen_end;
         case (state)
            ST_IDLE: begin
               bus.disp_we    <= 1'b0;
               bus.disp_clear <= 1'b0;
               if (trigger) begin
                  // Snapshot sees the pre-write shadow if the CPU writes this cycle.
                  active_x       <= shadow_x;
                  active_y       <= shadow_y;
                  active_valid   <= shadow_valid;
                  slot           <= '0;
                  bus.disp_clear <= 1'b1;
                  bus.busy       <= 1'b1;
                  state          <= ST_CLEAR;
               end
            end
            ST_CLEAR, ST_WRITE: begin
               bus.disp_clear <= 1'b0;
               if (trigger && bus.overrun_count != 8'hFF)
                  bus.overrun_count <= bus.overrun_count + 8'd1;
               if (slot == CNT_WIDTH'(MAX_BOIDS)) begin
                  bus.disp_we     <= 1'b0;
                  bus.busy        <= 1'b0;
                  bus.frame_count <= bus.frame_count + 16'd1;
                  state           <= ST_IDLE;
               end else begin
                  bus.disp_we <= slot_visible;
                  if (slot_visible)
                     bus.disp_addr <= pix_addr;
                  slot  <= slot + CNT_WIDTH'(1);
                  state <= ST_WRITE;
               end
            end
            default: begin
               bus.disp_we    <= 1'b0;
               bus.disp_clear <= 1'b0;
               bus.busy       <= 1'b0;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Randomised and directed bench for boid_frame_writer against a slot-table
// reference model.
module tb_boid_frame_writer;

   localparam int MAXB = 4;
   localparam int W    = 640;
   localparam int H    = 480;
   localparam int PAW  = 19;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   boid_frame_writer_if #(.PIXEL_ADDRESS_WIDTH(PAW)) bus ();

   boid_frame_writer #(
      .MAX_BOIDS           (MAXB),
      .VIDEO_WIDTH         (W),
      .VIDEO_HEIGHT        (H),
      .IDX_WIDTH           (2),
      .PIXEL_ADDRESS_WIDTH (PAW)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: CPU-visible slot table and expected counters.
   int m_x [MAXB];
   int m_y [MAXB];
   bit m_v [MAXB];
   int m_last;
   int m_frames;
   int m_over;

   function automatic void model_reset();
      for (int i = 0; i < MAXB; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_v[i] = 0;
      end
      m_last = 0; m_frames = 0; m_over = 0;
   endfunction

   function automatic void model_write(input logic [31:0] idx, input int x, input int y);
      if (idx < MAXB) begin
         m_x[idx] = x; m_y[idx] = y; m_v[idx] = 1'b1;
      end
   endfunction

   task automatic drive_write(input logic [31:0] idx, input int x, input int y);
      bus.cpu_we  = 1'b1;
      bus.cpu_idx = idx;
      bus.cpu_x   = 10'(x);
      bus.cpu_y   = 9'(y);
      model_write(idx, x, y);
   endtask

   task automatic cpu_write(input logic [31:0] idx, input int x, input int y);
      @(negedge clock);
      drive_write(idx, x, y);
      @(negedge clock);
      bus.cpu_we = 1'b0;
   endtask

   // Runs one frame and checks every output cycle. Optional: a CPU write in
   // the trigger cycle (sim_wr), a CPU write after sample mid_k, and a second
   // screen_end edge raised after sample ovr_k.
   task automatic run_frame(input string name, input bit sim_wr, input int mid_k, input int ovr_k,
                            input logic [31:0] w_idx, input int w_x, input int w_y);
      int sx [MAXB];
      int sy [MAXB];
      bit sv [MAXB];
      bit e_we, e_clear, e_busy;
      int j;
      @(negedge clock);
      for (int i = 0; i < MAXB; i++) begin
         sx[i] = m_x[i]; sy[i] = m_y[i]; sv[i] = m_v[i];
      end
      bus.screen_end = 1'b1;
      if (sim_wr) drive_write(w_idx, w_x, w_y);
      @(posedge clock);
      #1;
      for (int k = 1; k <= 2 + MAXB; k++) begin
         if (k > 1) begin
            @(posedge clock);
            #1;
         end
         e_clear = (k == 1);
         e_busy  = (k <= 1 + MAXB);
         e_we    = 1'b0;
         if (k >= 2 && k <= 1 + MAXB) begin
            j = k - 2;
            if (sv[j] && sx[j] < W && sy[j] < H) begin
               e_we   = 1'b1;
               m_last = sx[j] + W * sy[j];
            end
         end
         checks += 4;
         if (bus.disp_clear !== e_clear) begin
            errors++;
            $display("FAIL %s clear k=%0d got %b want %b", name, k, bus.disp_clear, e_clear);
         end
         if (bus.busy !== e_busy) begin
            errors++;
            $display("FAIL %s busy k=%0d got %b want %b", name, k, bus.busy, e_busy);
         end
         if (bus.disp_we !== e_we) begin
            errors++;
            $display("FAIL %s we k=%0d got %b want %b", name, k, bus.disp_we, e_we);
         end
         if (bus.disp_addr !== PAW'(m_last)) begin
            errors++;
            $display("FAIL %s addr k=%0d got %0d want %0d", name, k, bus.disp_addr, m_last);
         end
         @(negedge clock);
         bus.cpu_we     = 1'b0;
         bus.screen_end = (k == 1) || (ovr_k != 0 && k == ovr_k);
         if (mid_k != 0 && k == mid_k) drive_write(w_idx, w_x, w_y);
      end
      bus.cpu_we = 1'b0;
      m_frames++;
      if (ovr_k >= 3 && ovr_k <= 1 + MAXB && m_over < 255) m_over++;
      checks += 2;
      if (bus.frame_count !== 16'(m_frames)) begin
         errors++;
         $display("FAIL %s frame_count got %0d want %0d", name, bus.frame_count, m_frames);
      end
      if (bus.overrun_count !== 8'(m_over)) begin
         errors++;
         $display("FAIL %s overrun_count got %0d want %0d", name, bus.overrun_count, m_over);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (bus.disp_clear !== 1'b0 || bus.disp_we !== 1'b0 || bus.disp_addr !== '0 ||
          bus.busy !== 1'b0 || bus.frame_count !== 16'd0 || bus.overrun_count !== 8'd0) begin
         errors++;
         $display("FAIL %s outputs got clr=%b we=%b addr=%0d busy=%b fc=%0d oc=%0d want all 0",
                  name, bus.disp_clear, bus.disp_we, bus.disp_addr, bus.busy,
                  bus.frame_count, bus.overrun_count);
      end
   endtask

   task automatic test_reset();
      bus.cpu_we = 1'b0; bus.cpu_idx = '0; bus.cpu_x = '0; bus.cpu_y = '0;
      bus.screen_end = 1'b0;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      cpu_write(1, 10, 10);
      run_frame("single", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_bounds();
      cpu_write(0, 0, 0);
      cpu_write(1, 639, 479);
      cpu_write(2, 640, 5);
      cpu_write(3, 3, 480);
      run_frame("bounds", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_invalid_idx();
      cpu_write(7, 100, 100);
      cpu_write(32'h1000_0002, 200, 200);
      run_frame("invalid_idx", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_mid_write();
      cpu_write(0, 5, 5);
      run_frame("mid_write", 0, 3, 0, 0, 6, 6);
      run_frame("mid_write_next", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_simultaneous();
      run_frame("simultaneous", 1, 0, 0, 1, 7, 7);
      run_frame("simultaneous_next", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_overrun();
      run_frame("overrun", 0, 0, 3, 0, 0, 0);
      run_frame("after_overrun", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         for (int w = 0; w < 3; w++)
            cpu_write($urandom_range(0, 5), $urandom_range(0, 700), $urandom_range(0, 511));
         run_frame("random", 0, ($urandom_range(0, 1) != 0) ? $urandom_range(2, 5) : 0, 0,
                   $urandom_range(0, 4), $urandom_range(0, 700), $urandom_range(0, 511));
      end
   endtask

   task automatic test_reset_mid();
      cpu_write(0, 20, 20);
      cpu_write(1, 1, 1);
      @(negedge clock);
      bus.screen_end = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      bus.screen_end = 1'b0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid busy_before got %b want 1", bus.busy);
      end
      #1 reset_n = 1'b0;
      #1;
      check_all_zero("reset_mid");
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      run_frame("after_reset", 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_bounds();
      test_invalid_idx();
      test_mid_write();
      test_simultaneous();
      test_overrun();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
